// File: rtl/seq_multiplier_if.sv
// Request/response bundle between the execute stage and the sequential multiplier.
// The requester (master) holds enable until it samples done.
interface seq_multiplier_if #(
    parameter int WIDTH = 32
);
    logic               enable;
    logic               is_unsign;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] result;
    logic               done;
    logic               busy;

    modport master (
        output enable, is_unsign, a, b,
        input  result, done, busy
    );

    modport slave (
        input  enable, is_unsign, a, b,
        output result, done, busy
    );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add 32x32->64 multiplier; retires BITS_PER_CYCLE multiplier bits per CALC cycle.
//   state | meaning
//   IDLE  | waiting for enable
//   CALC  | accumulating partial products, one group of multiplier bits per edge
//   DONE  | product valid on result, done pulses for this single cycle
module seq_multiplier #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            sys_clk,
    input  logic            rst,
    seq_multiplier_if.slave bus
);
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic               neg;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] result_q;

    logic               start;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               neg_in;
    logic [2*WIDTH-1:0] partial;
    logic [2*WIDTH-1:0] acc_next;

    // Magnitudes are carried unsigned, so -0x80000000 correctly becomes 2^31.
    always_comb begin
        start  = bus.enable && (state == IDLE || state == DONE);
        a_mag  = (!bus.is_unsign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag  = (!bus.is_unsign && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        neg_in = !bus.is_unsign && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        partial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier[i]) begin
                partial = partial + (mcand << i);
            end
        end
        acc_next = acc + partial;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            neg      <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
        end else if (start) begin
            state  <= CALC;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            neg    <= neg_in;
            cnt    <= '0;
        end else begin
            case (state)
                CALC: begin
                    if (!bus.enable) begin
                        state <= IDLE;
                    end else begin
                        acc    <= acc_next;
                        mcand  <= mcand << BITS_PER_CYCLE;
                        mplier <= mplier >> BITS_PER_CYCLE;
                        cnt    <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            result_q <= neg ? -acc_next : acc_next;
                            state    <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.done   = (state == DONE);
    assign bus.busy   = (state == CALC);
endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized check of seq_multiplier against a plain-arithmetic product model,
// including back-to-back, abort and mid-operation reset scenarios.
module tb_seq_multiplier;
    logic sys_clk = 1'b0;
    logic rst     = 1'b1;

    seq_multiplier_if bus ();

    seq_multiplier dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input bit uns);
        logic [63:0] xe;
        logic [63:0] ye;
        if (uns) begin
            xe = {32'b0, x};
            ye = {32'b0, y};
        end else begin
            xe = {{32{x[31]}}, x};
            ye = {{32{y[31]}}, y};
        end
        return xe * ye;
    endfunction

    // Issue a request at the current negedge and follow it until done (bounded).
    // Called while in the DONE cycle with enable still high, this is a back-to-back start.
    task automatic do_mul(input logic [31:0] x, input logic [31:0] y, input bit uns, input string tag);
        logic [63:0] prev;
        logic [63:0] exp;
        int          cycles;
        int          busy_cnt;
        bit          seen;
        bit          moved;
        prev     = bus.result;
        exp      = ref_mul(x, y, uns);
        cycles   = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        moved    = 1'b0;
        bus.a         = x;
        bus.b         = y;
        bus.is_unsign = uns;
        bus.enable    = 1'b1;
        while (!seen && cycles < 100) begin
            @(negedge sys_clk);
            cycles++;
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                if (bus.busy) busy_cnt++;
                if (bus.result !== prev) moved = 1'b1;
                if (cycles == 4) begin
                    bus.a         = $urandom;
                    bus.b         = $urandom;
                    bus.is_unsign = 1'($urandom_range(0, 1));
                end
            end
        end
        check({tag, " latency"}, 64'(cycles), 64'd33);
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd32);
        check({tag, " result_held"}, 64'(moved), 64'd0);
        check({tag, " product"}, bus.result, exp);
    endtask

    task automatic end_op(input string tag);
        bus.enable = 1'b0;
        @(negedge sys_clk);
        check({tag, " done_pulse"}, 64'(bus.done), 64'd0);
        check({tag, " idle_busy"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        logic [63:0] prev;
        logic [31:0] x;
        logic [31:0] y;
        bit          seen;
        logic [31:0] pool [6];
        pool[0] = 32'h0000_0000;
        pool[1] = 32'h0000_0001;
        pool[2] = 32'hFFFF_FFFF;
        pool[3] = 32'h8000_0000;
        pool[4] = 32'h7FFF_FFFF;
        pool[5] = 32'h0000_FFFF;

        bus.enable    = 1'b0;
        bus.is_unsign = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (2) @(negedge sys_clk);
        check("reset result", bus.result, 64'h0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;
        @(negedge sys_clk);

        do_mul(32'd7, 32'd6, 1'b1, "u7x6");
        check("u7x6 value", bus.result, 64'h0000_0000_0000_002A);
        end_op("u7x6");

        do_mul(32'hFFFF_FFFD, 32'd5, 1'b0, "s_m3x5");
        check("s_m3x5 value", bus.result, 64'hFFFF_FFFF_FFFF_FFF1);
        end_op("s_m3x5");

        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "s_m1xm1");
        check("s_m1xm1 value", bus.result, 64'h0000_0000_0000_0001);
        end_op("s_m1xm1");

        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "u_maxsq");
        check("u_maxsq value", bus.result, 64'hFFFF_FFFE_0000_0001);
        end_op("u_maxsq");

        do_mul(32'h8000_0000, 32'h8000_0000, 1'b0, "s_minsq");
        check("s_minsq value", bus.result, 64'h4000_0000_0000_0000);
        end_op("s_minsq");

        do_mul(32'h0, 32'h1234_5678, 1'b0, "zero");
        end_op("zero");

        // Back-to-back: second request starts from the DONE cycle.
        do_mul(32'h0001_0003, 32'h0000_0100, 1'b1, "b2b_first");
        do_mul(32'd3, 32'd4, 1'b1, "b2b_second");
        check("b2b_second value", bus.result, 64'h0000_0000_0000_000C);
        end_op("b2b_second");

        // Abort after 10 CALC cycles.
        prev          = bus.result;
        bus.a         = 32'h0000_0055;
        bus.b         = 32'h0000_0077;
        bus.is_unsign = 1'b1;
        bus.enable    = 1'b1;
        repeat (10) @(negedge sys_clk);
        check("abort busy_before", 64'(bus.busy), 64'd1);
        bus.enable = 1'b0;
        seen = 1'b0;
        @(negedge sys_clk);
        check("abort busy_after", 64'(bus.busy), 64'd0);
        repeat (40) begin
            if (bus.done) seen = 1'b1;
            @(negedge sys_clk);
        end
        check("abort no_done", 64'(seen), 64'd0);
        check("abort result_kept", bus.result, prev);
        do_mul(32'h0000_0055, 32'h0000_0077, 1'b1, "after_abort");
        end_op("after_abort");

        // Asynchronous reset in the middle of CALC.
        bus.a         = 32'hDEAD_BEEF;
        bus.b         = 32'h0BAD_F00D;
        bus.is_unsign = 1'b0;
        bus.enable    = 1'b1;
        repeat (15) @(negedge sys_clk);
        rst = 1'b1;
        #1;
        check("midrst result", bus.result, 64'h0);
        check("midrst busy", 64'(bus.busy), 64'd0);
        check("midrst done", 64'(bus.done), 64'd0);
        bus.enable = 1'b0;
        @(negedge sys_clk);
        rst = 1'b0;
        @(negedge sys_clk);
        check("midrst idle_done", 64'(bus.done), 64'd0);
        do_mul(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, "after_rst");
        end_op("after_rst");

        for (int k = 0; k < 16; k++) begin
            x = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : 32'($urandom);
            y = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : 32'($urandom);
            do_mul(x, y, 1'($urandom_range(0, 1)), $sformatf("rand%0d", k));
            if ($urandom_range(0, 2) != 0) end_op($sformatf("rand%0d", k));
        end
        end_op("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
